// File: rtl/rmw_store_pkg.sv
// Shared types for the read-modify-write store unit: store-type codes, FSM states
// and the payload-size helper.
package rmw_store_pkg;

   localparam logic [1:0] ST_SB = 2'd0;
   localparam logic [1:0] ST_SH = 2'd1;
   localparam logic [1:0] ST_SW = 2'd2;
   localparam logic [1:0] ST_SD = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      MRG,
      WR,
      FLT
   } state_t;

   // Payload size in bytes for each store type.
   function automatic logic [3:0] store_size(input logic [1:0] st_type);
      logic [3:0] sz;
      case (st_type)
         ST_SB:   sz = 4'd1;
         ST_SH:   sz = 4'd2;
         ST_SW:   sz = 4'd4;
         default: sz = 4'd8;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane logic: byte enables, lane-shifted store data merged over the
// read word, and the alignment check for the given store type and byte offset.
module store_lane_merge
   import rmw_store_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int BYTES  = DATA_W / 8,
   localparam int OFF_W  = $clog2(BYTES)
) (
   input  logic [1:0]        st_type,
   input  logic [OFF_W-1:0]  off,
   input  logic [DATA_W-1:0] data,
   input  logic [DATA_W-1:0] rd_word,
   output logic [BYTES-1:0]  be,
   output logic [DATA_W-1:0] merged,
   output logic              misalign
);

   logic [15:0]       mask;
   logic [15:0]       be_wide;
   logic [DATA_W-1:0] shifted;

   always_comb begin
      mask    = (16'd1 << store_size(st_type)) - 16'd1;
      be_wide = mask << off;
      shifted = data << {off, 3'b000};
   end

   assign be = be_wide[BYTES-1:0];

   for (genvar i = 0; i < BYTES; i++) begin : g_lane
      assign merged[8*i +: 8] = be[i] ? shifted[8*i +: 8] : rd_word[8*i +: 8];
   end

   // SD can never be aligned on a 32-bit word.
   always_comb begin
      misalign = 1'b0;
      case (st_type)
         ST_SH:   misalign = off[0];
         ST_SW:   misalign = |off[1:0];
         ST_SD:   misalign = (DATA_W == 32) || (|off);
         default: misalign = 1'b0;
      endcase
   end

endmodule

// File: rtl/rmw_store_unit.sv
// Store engine between MEM and a word-wide synchronous memory: full-width stores
// write directly, sub-word stores read, merge and write back the containing word.
module rmw_store_unit
   import rmw_store_pkg::*;
#(
   parameter  int DATA_W  = 32,
   parameter  int ADDR_W  = 32,
   localparam int BYTES   = DATA_W / 8,
   localparam int OFF_W   = $clog2(BYTES),
   localparam int WADDR_W = ADDR_W - OFF_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [ADDR_W-1:0]  req_addr,
   input  logic [DATA_W-1:0]  req_data,
   input  logic [1:0]         req_type,
   output logic               busy,
   output logic               mem_rd_en,
   output logic [WADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0]  mem_rd_data,
   output logic               mem_wr_en,
   output logic [WADDR_W-1:0] mem_wr_addr,
   output logic [DATA_W-1:0]  mem_wr_data,
   output logic [BYTES-1:0]   mem_wr_be,
   output logic               done,
   output logic               fault
);

   if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
      $error("rmw_store_unit: DATA_W must be 32 or 64");
   end

   state_t state, nxt;

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [1:0]        type_q;
   logic [BYTES-1:0]  be_q;
   logic [DATA_W-1:0] wdata_q;

   logic              idle;
   logic              accept;
   logic              full;
   logic [1:0]        m_type;
   logic [OFF_W-1:0]  m_off;
   logic [DATA_W-1:0] m_data;
   logic [BYTES-1:0]  be;
   logic [DATA_W-1:0] merged;
   logic              misalign;

   assign idle   = (state == IDLE);
   assign accept = req_valid && idle;
   assign full   = (int'(store_size(req_type)) == BYTES);

   // The lane logic sees the live request while idle (to classify it at accept)
   // and the latched request afterwards (to build the merged word in MRG).
   assign m_type = idle ? req_type                : type_q;
   assign m_off  = idle ? req_addr[OFF_W-1:0]     : addr_q[OFF_W-1:0];
   assign m_data = idle ? req_data                : data_q;

   store_lane_merge #(.DATA_W(DATA_W)) u_merge (
      .st_type  (m_type),
      .off      (m_off),
      .data     (m_data),
      .rd_word  (mem_rd_data),
      .be       (be),
      .merged   (merged),
      .misalign (misalign)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE: if (accept) nxt = misalign ? FLT : (full ? WR : RD);
         RD:   nxt = MRG;
         MRG:  nxt = WR;
         WR:   nxt = IDLE;
         FLT:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Full-width stores write req_data as-is; sub-word stores overwrite it in MRG.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         data_q  <= '0;
         type_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         addr_q  <= req_addr;
         data_q  <= req_data;
         type_q  <= req_type;
         be_q    <= be;
         wdata_q <= req_data;
      end else if (state == MRG) begin
         wdata_q <= merged;
      end
   end

   always_comb begin
      req_ready   = idle;
      busy        = !idle;
      mem_rd_en   = 1'b0;
      mem_rd_addr = '0;
      mem_wr_en   = 1'b0;
      mem_wr_addr = '0;
      mem_wr_data = '0;
      mem_wr_be   = '0;
      done        = 1'b0;
      fault       = 1'b0;
      case (state)
         RD: begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = addr_q[ADDR_W-1:OFF_W];
         end
         WR: begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = addr_q[ADDR_W-1:OFF_W];
            mem_wr_data = wdata_q;
            mem_wr_be   = be_q;
            done        = 1'b1;
         end
         FLT: fault = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rmw_store_unit.sv
// Scoreboard bench for rmw_store_unit at DATA_W=32 and DATA_W=64: stimulus pushes
// expected memory events, a negedge monitor pops and compares them.
module tb_rmw_store_unit;
   import rmw_store_pkg::*;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   longint cyc = 0;
   int     n_chk = 0;
   int     n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // 32-bit instance
   logic        v32 = 1'b0, r32, b32, rde32, wre32, dn32, f32;
   logic [31:0] a32 = '0, d32 = '0, rdd32 = '0, wd32;
   logic [1:0]  t32 = '0;
   logic [29:0] ra32, wa32;
   logic [3:0]  be32;

   // 64-bit instance
   logic        v64 = 1'b0, r64, b64, rde64, wre64, dn64, f64;
   logic [31:0] a64 = '0;
   logic [63:0] d64 = '0, rdd64 = '0, wd64;
   logic [1:0]  t64 = '0;
   logic [28:0] ra64, wa64;
   logic [7:0]  be64;

   rmw_store_unit #(.DATA_W(32), .ADDR_W(32)) u32 (
      .clk(clk), .rst_n(rst_n), .req_valid(v32), .req_ready(r32), .req_addr(a32),
      .req_data(d32), .req_type(t32), .busy(b32), .mem_rd_en(rde32), .mem_rd_addr(ra32),
      .mem_rd_data(rdd32), .mem_wr_en(wre32), .mem_wr_addr(wa32), .mem_wr_data(wd32),
      .mem_wr_be(be32), .done(dn32), .fault(f32));

   rmw_store_unit #(.DATA_W(64), .ADDR_W(32)) u64 (
      .clk(clk), .rst_n(rst_n), .req_valid(v64), .req_ready(r64), .req_addr(a64),
      .req_data(d64), .req_type(t64), .busy(b64), .mem_rd_en(rde64), .mem_rd_addr(ra64),
      .mem_rd_data(rdd64), .mem_wr_en(wre64), .mem_wr_addr(wa64), .mem_wr_data(wd64),
      .mem_wr_be(be64), .done(dn64), .fault(f64));

   // Synchronous memories: read data returns the cycle after the strobe.
   logic [31:0] m32 [logic [29:0]];
   logic [63:0] m64 [logic [28:0]];
   always @(posedge clk) begin
      if (rde32) rdd32 <= m32.exists(ra32) ? m32[ra32] : 32'h0;
      if (wre32) m32[wa32] = wd32;
      if (rde64) rdd64 <= m64.exists(ra64) ? m64[ra64] : 64'h0;
      if (wre64) m64[wa64] = wd64;
   end

   typedef struct {
      bit           flt;
      longint       cyc;
      logic [63:0]  addr;
      logic [63:0]  data;
      logic [7:0]   be;
   } exp_t;
   typedef struct {
      longint       cyc;
      logic [63:0]  addr;
   } rd_t;

   exp_t eq32[$], eq64[$];
   rd_t  rq32[$], rq64[$];

   task automatic check(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[dut%0d]: got %0h expected %0h", nm, id, act, exp);
   endtask

   task automatic mon(input int id, input logic wr, input logic [63:0] wa, input logic [63:0] wd,
                      input logic [7:0] be, input logic rd, input logic [63:0] ra,
                      input logic flt, input logic dn);
      exp_t e;
      rd_t  r;
      bit   have;
      if (rd) begin
         have = (id == 0) ? (rq32.size() > 0) : (rq64.size() > 0);
         check("rd_expected", id, 64'(have), 64'd1);
         if (have) begin
            r = (id == 0) ? rq32.pop_front() : rq64.pop_front();
            check("rd_cycle", id, cyc, r.cyc);
            check("rd_addr", id, ra, r.addr);
         end
      end
      if (wr || flt) begin
         have = (id == 0) ? (eq32.size() > 0) : (eq64.size() > 0);
         check("event_expected", id, 64'(have), 64'd1);
         if (have) begin
            e = (id == 0) ? eq32.pop_front() : eq64.pop_front();
            check("event_is_fault", id, 64'(flt), 64'(e.flt));
            check("event_cycle", id, cyc, e.cyc);
            if (wr) begin
               check("wr_addr", id, wa, e.addr);
               check("wr_data", id, wd, e.data);
               check("wr_be", id, 64'(be), 64'(e.be));
            end
         end
      end
      check("done_with_wr", id, 64'(dn), 64'(wr));
      if (!wr) check("wr_gated", id, 64'(|{wa, wd, be}), 64'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, wre32, 64'(wa32), 64'(wd32), 8'(be32), rde32, 64'(ra32), f32, dn32);
         mon(1, wre64, 64'(wa64), wd64, be64, rde64, 64'(ra64), f64, dn64);
      end
   end

   // kind: 0 direct write, 1 read-merge-write, 2 fault, 3 read only (interrupted)
   task automatic issue(input int id, input logic [31:0] addr, input logic [63:0] data,
                        input logic [1:0] typ, input bit hold, input int kind,
                        input logic [63:0] waddr, input logic [63:0] wdata,
                        input logic [7:0] be, output longint t);
      int n;
      @(negedge clk);
      if (id == 0) begin a32 = addr; d32 = data[31:0]; t32 = typ; v32 = 1'b1; end
      else         begin a64 = addr; d64 = data;       t64 = typ; v64 = 1'b1; end
      n = 0;
      while (!((id == 0) ? r32 : r64) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("accept_ready", id, 64'((id == 0) ? r32 : r64), 64'd1);
      t = cyc;
      if (kind == 1 || kind == 3) begin
         if (id == 0) rq32.push_back('{t + 1, waddr});
         else         rq64.push_back('{t + 1, waddr});
      end
      if (kind == 0 || kind == 1 || kind == 2) begin
         exp_t e;
         e.flt  = (kind == 2);
         e.cyc  = (kind == 1) ? t + 3 : t + 1;
         e.addr = waddr;
         e.data = wdata;
         e.be   = be;
         if (id == 0) eq32.push_back(e);
         else         eq64.push_back(e);
      end
      if (!hold) begin
         // Scribble the request bus: the unit must be working from its latched copy.
         @(negedge clk);
         if (id == 0) begin v32 = 1'b0; d32 = '1; a32 = '1; end
         else         begin v64 = 1'b0; d64 = '1; a64 = '1; end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   logic [31:0] burst_wd [8] = '{32'h00000010, 32'h00001110, 32'h00121110, 32'h13121110,
                                 32'h00000014, 32'h00001514, 32'h00161514, 32'h17161514};

   initial begin
      longint t, tprev;
      repeat (2) @(negedge clk);
      #1;
      check("rst_ready", 0, 64'(r32), 64'd1);
      check("rst_busy", 0, 64'(b32), 64'd0);
      check("rst_strobes", 0, 64'({rde32, wre32, dn32, f32}), 64'd0);
      check("rst_outs", 0, 64'(|{ra32, wa32, wd32, be32}), 64'd0);
      check("rst_ready", 1, 64'(r64), 64'd1);
      check("rst_strobes", 1, 64'({rde64, wre64, dn64, f64, b64}), 64'd0);
      @(negedge clk) rst_n = 1'b1;

      // DATA_W=32
      issue(0, 32'h100, 64'h11223344, ST_SW, 0, 0, 64'h40, 64'h11223344, 8'hF, t);
      issue(0, 32'h103, 64'hAB,       ST_SB, 0, 1, 64'h40, 64'hAB223344, 8'h8, t);
      issue(0, 32'h100, 64'h11223344, ST_SW, 0, 0, 64'h40, 64'h11223344, 8'hF, t);
      issue(0, 32'h102, 64'hBEEF,     ST_SH, 0, 1, 64'h40, 64'hBEEF3344, 8'hC, t);
      issue(0, 32'h101, 64'h1234,     ST_SH, 0, 2, 64'h0,  64'h0,        8'h0, t);
      issue(0, 32'h200, 64'hDEADBEEF, ST_SW, 0, 0, 64'h80, 64'hDEADBEEF, 8'hF, t);
      issue(0, 32'h200, 64'h55AA55AA, ST_SD, 0, 2, 64'h0,  64'h0,        8'h0, t);
      issue(0, 32'h202, 64'h77,       ST_SW, 0, 2, 64'h0,  64'h0,        8'h0, t);

      // DATA_W=64
      issue(1, 32'h10, 64'h0123456789ABCDEF, ST_SD, 0, 0, 64'h2, 64'h0123456789ABCDEF, 8'hFF, t);
      issue(1, 32'h14, 64'hCAFEF00D,         ST_SW, 0, 1, 64'h2, 64'hCAFEF00D89ABCDEF, 8'hF0, t);
      issue(1, 32'h18, 64'h1122334455667788, ST_SD, 0, 0, 64'h3, 64'h1122334455667788, 8'hFF, t);
      issue(1, 32'h1C, 64'h9,                ST_SD, 0, 2, 64'h0, 64'h0, 8'h0, t);
      issue(1, 32'h16, 64'h9,                ST_SW, 0, 2, 64'h0, 64'h0, 8'h0, t);
      issue(1, 32'h1E, 64'hA5A5,             ST_SH, 0, 1, 64'h3, 64'hA5A5334455667788, 8'hC0, t);

      // Back-to-back SB with req_valid held high.
      tprev = 0;
      for (int i = 0; i < 8; i++) begin
         issue(0, 32'h300 + 32'(i), 64'(8'h10 + 8'(i)), ST_SB, 1, 1,
               64'(30'hC0 + 30'(i / 4)), 64'(burst_wd[i]), 8'(4'b0001 << (i % 4)), t);
         if (i > 0) check("burst_spacing", 0, 64'(t - tprev), 64'd4);
         tprev = t;
      end
      @(negedge clk) v32 = 1'b0;
      repeat (4) @(negedge clk);

      // Reset while in MRG: the interrupted store must never write.
      issue(0, 32'h104, 64'h55, ST_SB, 0, 3, 64'h41, 64'h0, 8'h0, t);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_ready", 0, 64'(r32), 64'd1);
      check("midrst_busy", 0, 64'(b32), 64'd0);
      check("midrst_strobes", 0, 64'({rde32, wre32, dn32, f32}), 64'd0);
      check("midrst_outs", 0, 64'(|{ra32, wa32, wd32, be32}), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (6) @(negedge clk);
      issue(0, 32'h104, 64'h66, ST_SB, 0, 1, 64'h41, 64'h00000066, 8'h1, t);

      repeat (8) @(negedge clk);
      check("sb_drained", 0, 64'(eq32.size() + rq32.size()), 64'd0);
      check("sb_drained", 1, 64'(eq64.size() + rq64.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
